// File: rtl/mult_arbiter_float32.sv
// ---------------------------------------------------------------------------
// mult_arbiter_float32
// Round-robin arbiter that shares one pipelined 24x24 mantissa multiplier
// between NUM_REQ requesters. A winning operand pair is registered into the
// multiplier. A {valid, id} tag travels down a shift pipeline that matches the
// multiplier latency, and each 48-bit product is steered back to its owner.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   hold            block new grants; in-flight work still drains
//   req_valid       per-requester operand valid
//   req_a, req_b    packed 24-bit mantissas, requester i at [24i +: 24]
//   req_ready       one-hot grant (combinational)
//   mul_valid_in    issue strobe to the multiplier
//   mul_a, mul_b    registered operands to the multiplier
//   mul_valid_out   product valid from the multiplier
//   mul_data        48-bit product from the multiplier
//   res_valid       one-hot result strobe, one cycle
//   res_id          owner index of the current result
//   res_data        48-bit product, shared by all requesters
//   in_flight       operations issued and not yet returned
//   err             sticky tag/valid mismatch flag
// ---------------------------------------------------------------------------
module mult_arbiter_float32 #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*24-1:0]   req_a,
  input  logic [NUM_REQ*24-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    mul_valid_in,
  output logic [23:0]             mul_a,
  output logic [23:0]             mul_b,
  input  logic                    mul_valid_out,
  input  logic [47:0]             mul_data,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [47:0]             res_data,
  output logic [ID_W+1:0]         in_flight,
  output logic                    err
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned CNT_W  = ID_W + 2;
  localparam int unsigned SUM_W  = ID_W + 1;

  // State registers
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic                          mul_valid_q, mul_valid_d;
  logic [MANT_W-1:0]             mul_a_q, mul_a_d;
  logic [MANT_W-1:0]             mul_b_q, mul_b_d;
  logic [ID_W-1:0]               issue_id_q, issue_id_d;
  logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]            res_valid_q, res_valid_d;
  logic [ID_W-1:0]               res_id_q, res_id_d;
  logic [PROD_W-1:0]             res_data_q, res_data_d;
  logic [CNT_W-1:0]              in_flight_q, in_flight_d;
  logic                          err_q, err_d;

  // Combinational grant
  logic                          grant_vld_c;
  logic [ID_W-1:0]               grant_id_c;
  logic [SUM_W-1:0]              scan_sum;
  logic [ID_W-1:0]               scan_idx;
  logic                          ret_tag;
  logic [ID_W-1:0]               ret_id;

  assign ret_tag = tag_vld_q[MUL_LAT-1];
  assign ret_id  = tag_id_q[MUL_LAT-1];

  // Round-robin scan: first requester at or after ptr (mod NUM_REQ) wins
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    req_ready   = '0;
    if (!hold) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, ptr_q} + SUM_W'(k);
        if (scan_sum >= SUM_W'(NUM_REQ)) scan_sum = scan_sum - SUM_W'(NUM_REQ);
        scan_idx = scan_sum[ID_W-1:0];
        if (!grant_vld_c && req_valid[scan_idx]) begin
          grant_vld_c = 1'b1;
          grant_id_c  = scan_idx;
        end
      end
    end
    if (grant_vld_c) req_ready[grant_id_c] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    ptr_d       = ptr_q;
    mul_valid_d = grant_vld_c;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    issue_id_d  = issue_id_q;
    res_valid_d = '0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    in_flight_d = in_flight_q;
    err_d       = err_q;

    if (grant_vld_c) begin
      ptr_d      = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
      issue_id_d = grant_id_c;
    end

    // Operand capture from the one-hot winner; holds value when idle
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        mul_a_d = req_a[i*MANT_W +: MANT_W];
        mul_b_d = req_b[i*MANT_W +: MANT_W];
      end
    end

    // Tag shifts every cycle so bubbles stay aligned with the multiplier
    tag_vld_d = {tag_vld_q[MUL_LAT-2:0], mul_valid_q};
    tag_id_d  = {tag_id_q[MUL_LAT-2:0], issue_id_q};

    if (mul_valid_out && ret_tag) begin
      res_valid_d[ret_id] = 1'b1;
      res_id_d            = ret_id;
      res_data_d          = mul_data;
    end

    // Count leaves on tag exit so a lost product cannot wedge the counter
    if (grant_vld_c && !ret_tag)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!grant_vld_c && ret_tag) in_flight_d = in_flight_q - CNT_W'(1);

    if (mul_valid_out != ret_tag) err_d = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_id_q  <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      res_valid_q <= '0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      issue_id_q  <= issue_id_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  assign mul_valid_in = mul_valid_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_data     = res_data_q;
  assign in_flight    = in_flight_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mult_arbiter_float32.sv
// ---------------------------------------------------------------------------
// tb_mult_arbiter_float32
// Directed bench for mult_arbiter_float32 with a 4-stage behavioural
// multiplier that shares the arbiter reset.
// ---------------------------------------------------------------------------
module tb_mult_arbiter_float32;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned MUL_LAT = 4;

  logic                  clk;
  logic                  rst;
  logic                  hold;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*24-1:0] req_a;
  logic [NUM_REQ*24-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_valid_in;
  logic [23:0]           mul_a;
  logic [23:0]           mul_b;
  logic                  mul_valid_out;
  logic [47:0]           mul_data;
  logic [NUM_REQ-1:0]    res_valid;
  logic [ID_W-1:0]       res_id;
  logic [47:0]           res_data;
  logic [ID_W+1:0]       in_flight;
  logic                  err;

  int vecs;
  int miss;

  mult_arbiter_float32 #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_out(mul_valid_out), .mul_data(mul_data),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .in_flight(in_flight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: 4 register stages, flushed by the shared reset
  logic [MUL_LAT-1:0] mv;
  logic [47:0]        md0, md1, md2, md3;
  logic               inj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv  <= '0;
      md0 <= '0;
      md1 <= '0;
      md2 <= '0;
      md3 <= '0;
    end else begin
      mv  <= {mv[MUL_LAT-2:0], mul_valid_in};
      md0 <= 48'(mul_a) * 48'(mul_b);
      md1 <= md0;
      md2 <= md1;
      md3 <= md2;
    end
  end

  assign mul_valid_out = mv[MUL_LAT-1] | inj;
  assign mul_data      = md3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
    req_a[i*24 +: 24] = a;
    req_b[i*24 +: 24] = b;
  endtask

  task automatic test_reset();
    vecs++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    vecs++; if (mul_valid_in !== 1'b0) begin miss++; $display("FAIL reset_mul_valid_in: got %b want 0", mul_valid_in); end
    vecs++; if (mul_a !== 24'h0 || mul_b !== 24'h0) begin miss++; $display("FAIL reset_mul_ab: got %h/%h want 0/0", mul_a, mul_b); end
    vecs++; if (res_valid !== 4'b0000) begin miss++; $display("FAIL reset_res_valid: got %b want 0000", res_valid); end
    vecs++; if (res_id !== 2'd0 || res_data !== 48'h0) begin miss++; $display("FAIL reset_res: got id %0d data %h want 0/0", res_id, res_data); end
    vecs++; if (in_flight !== 4'd0) begin miss++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_single();
    set_op(2, 24'h800000, 24'hC00000);
    req_valid = 4'b0100;
    #1;
    vecs++; if (req_ready !== 4'b0100) begin miss++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    vecs++; if (mul_valid_in !== 1'b1 || mul_a !== 24'h800000 || mul_b !== 24'hC00000) begin
      miss++; $display("FAIL single_issue: got v=%b a=%h b=%h want 1/800000/c00000", mul_valid_in, mul_a, mul_b); end
    vecs++; if (in_flight !== 4'd1) begin miss++; $display("FAIL single_in_flight1: got %0d want 1", in_flight); end
    tick();
    vecs++; if (mul_valid_in !== 1'b0) begin miss++; $display("FAIL single_issue_pulse: got %b want 0", mul_valid_in); end
    for (int k = 2; k < 6; k++) begin
      vecs++; if (res_valid !== 4'b0000) begin miss++; $display("FAIL single_early_res: cycle T+%0d got %b want 0000", k, res_valid); end
      tick();
    end
    vecs++; if (res_valid !== 4'b0100 || res_id !== 2'd2 || res_data !== 48'h600000000000) begin
      miss++; $display("FAIL single_result: got v=%b id=%0d d=%h want 0100/2/600000000000", res_valid, res_id, res_data); end
    vecs++; if (in_flight !== 4'd0) begin miss++; $display("FAIL single_in_flight0: got %0d want 0", in_flight); end
    tick();
    vecs++; if (res_valid !== 4'b0000) begin miss++; $display("FAIL single_res_pulse: got %b want 0000", res_valid); end
  endtask

  task automatic test_all_requesters();
    logic [3:0]  exp_ready;
    logic [3:0]  exp_res;
    logic [47:0] exp_data;
    int          exp_if;
    int          r;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 24'(i + 1), 24'd3);
    for (int j = 0; j <= 14; j++) begin
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_ready = (j < 8) ? (4'b0001 << (j % 4)) : 4'b0000;
      vecs++; if (req_ready !== exp_ready) begin miss++; $display("FAIL all_grant: cycle %0d got %b want %b", j, req_ready, exp_ready); end
      r = (j >= 6) ? ((j - 5 < 8) ? j - 5 : 8) : 0;
      exp_if = ((j < 8) ? j : 8) - r;
      vecs++; if (in_flight !== 4'(exp_if)) begin miss++; $display("FAIL all_in_flight: cycle %0d got %0d want %0d", j, in_flight, exp_if); end
      if (j >= 6 && j < 14) begin
        exp_res  = 4'b0001 << ((j - 6) % 4);
        exp_data = 48'(3 * (((j - 6) % 4) + 1));
        vecs++; if (res_valid !== exp_res || res_id !== 2'((j - 6) % 4) || res_data !== exp_data) begin
          miss++; $display("FAIL all_result: cycle %0d got v=%b id=%0d d=%h want %b/%0d/%h", j, res_valid, res_id, res_data, exp_res, (j - 6) % 4, exp_data); end
      end else begin
        vecs++; if (res_valid !== 4'b0000) begin miss++; $display("FAIL all_no_result: cycle %0d got %b want 0000", j, res_valid); end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    // pointer is 0 here (last grant went to 3)
    set_op(3, 24'd5, 24'd7);
    set_op(1, 24'd2, 24'd11);
    req_valid = 4'b1000;
    #1;
    vecs++; if (req_ready !== 4'b1000) begin miss++; $display("FAIL fair_grant3: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b1010;
    #1;
    vecs++; if (req_ready !== 4'b0010) begin miss++; $display("FAIL fair_grant1_first: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b1010;
    #1;
    vecs++; if (req_ready !== 4'b1000) begin miss++; $display("FAIL fair_grant3_next: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    vecs++; if (res_valid !== 4'b1000 || res_id !== 2'd3 || res_data !== 48'd35) begin
      miss++; $display("FAIL fair_res0: got v=%b id=%0d d=%h want 1000/3/23", res_valid, res_id, res_data); end
    tick();
    vecs++; if (res_valid !== 4'b0010 || res_id !== 2'd1 || res_data !== 48'd22) begin
      miss++; $display("FAIL fair_res1: got v=%b id=%0d d=%h want 0010/1/16", res_valid, res_id, res_data); end
    tick();
    vecs++; if (res_valid !== 4'b1000 || res_id !== 2'd3 || res_data !== 48'd35) begin
      miss++; $display("FAIL fair_res2: got v=%b id=%0d d=%h want 1000/3/23", res_valid, res_id, res_data); end
    tick();
    vecs++; if (res_valid !== 4'b0000 || in_flight !== 4'd0) begin
      miss++; $display("FAIL fair_drain: got v=%b if=%0d want 0000/0", res_valid, in_flight); end
  endtask

  task automatic test_hold();
    // pointer is 0 here
    set_op(0, 24'd4, 24'd4);
    set_op(2, 24'd6, 24'd6);
    req_valid = 4'b0001;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin miss++; $display("FAIL hold_pre_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) begin
      hold = 1'b1;
      req_valid = 4'b0101;
      #1;
      vecs++; if (req_ready !== 4'b0000) begin miss++; $display("FAIL hold_blocked: hold cycle %0d got %b want 0000", k, req_ready); end
      if (k == 2) begin
        vecs++; if (res_valid !== 4'b0001 || res_id !== 2'd0 || res_data !== 48'd16) begin
          miss++; $display("FAIL hold_drain_res: got v=%b id=%0d d=%h want 0001/0/10", res_valid, res_id, res_data); end
      end
      tick();
    end
    hold = 1'b0;
    #1;
    vecs++; if (req_ready !== 4'b0100) begin miss++; $display("FAIL hold_release_grant: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0001;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin miss++; $display("FAIL hold_wrap_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick(); tick(); tick(); tick();
    vecs++; if (res_valid !== 4'b0100 || res_id !== 2'd2 || res_data !== 48'd36) begin
      miss++; $display("FAIL hold_res2: got v=%b id=%0d d=%h want 0100/2/24", res_valid, res_id, res_data); end
    tick();
    vecs++; if (res_valid !== 4'b0001 || res_id !== 2'd0 || res_data !== 48'd16) begin
      miss++; $display("FAIL hold_res0: got v=%b id=%0d d=%h want 0001/0/10", res_valid, res_id, res_data); end
    tick();
    vecs++; if (in_flight !== 4'd0) begin miss++; $display("FAIL hold_drain: got %0d want 0", in_flight); end
  endtask

  task automatic test_reset_in_flight();
    logic [3:0] exp_ready;
    // pointer is 1 here: grants go 1,2,3,0
    for (int k = 0; k < 4; k++) begin
      req_valid = 4'b1111;
      #1;
      exp_ready = 4'b0001 << ((k + 1) % 4);
      vecs++; if (req_ready !== exp_ready) begin miss++; $display("FAIL rst_fill_grant: step %0d got %b want %b", k, req_ready, exp_ready); end
      tick();
    end
    req_valid = 4'b0000;
    #1;
    vecs++; if (in_flight !== 4'd4) begin miss++; $display("FAIL rst_in_flight4: got %0d want 4", in_flight); end
    rst = 1'b1;
    #1;
    test_reset();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vecs++; if (res_valid !== 4'b0000 || err !== 1'b0 || in_flight !== 4'd0) begin
        miss++; $display("FAIL rst_flush: cycle %0d got v=%b err=%b if=%0d want 0000/0/0", k, res_valid, err, in_flight); end
      tick();
    end
    // pointer back at 0 selects 0 over 3
    req_valid = 4'b1001;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin miss++; $display("FAIL rst_ptr_cleared: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic test_mismatch();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    vecs++; if (err !== 1'b1 || res_valid !== 4'b0000) begin
      miss++; $display("FAIL mismatch_set: got err=%b v=%b want 1/0000", err, res_valid); end
    tick(); tick();
    vecs++; if (err !== 1'b1) begin miss++; $display("FAIL mismatch_sticky: got %b want 1", err); end
    vecs++; if (in_flight !== 4'd0 || res_valid !== 4'b0000) begin
      miss++; $display("FAIL mismatch_side: got if=%0d v=%b want 0/0000", in_flight, res_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL mismatch_clear: got %b want 0", err); end
  endtask

  initial begin
    vecs      = 0;
    miss      = 0;
    rst       = 1'b1;
    hold      = 1'b0;
    inj       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    test_single();
    test_all_requesters();
    test_fairness();
    test_hold();
    test_reset_in_flight();
    test_mismatch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mult_arbiter_float32.md
# mult_arbiter_float32

Round-robin arbiter that shares one 24x24 mantissa array multiplier (4-cycle, one-result-per-cycle pipeline) between NUM_REQ requesters in the FP32 datapath. It registers the winning operand pair into the multiplier and carries a requester tag down a matching shift pipeline. It then routes each 48-bit product back to the requester that issued it. It sits between the neuron/MAC units of a layer and the single shared multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, tag width, equal to clog2(NUM_REQ)
- MUL_LAT, 4, multiplier latency in cycles from mul_valid_in to mul_valid_out
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- hold  input  1  when high, no new grants are issued; in-flight operations complete
- req_valid  input  NUM_REQ  per-requester operand-valid
- req_a  input  NUM_REQ*24  packed mantissa A, requester i at [24i+23:24i]
- req_b  input  NUM_REQ*24  packed mantissa B, same packing
- req_ready  output  NUM_REQ  one-hot grant, combinational
- mul_valid_in  output  1  to multiplier valid_in
- mul_a, mul_b  output  24  to multiplier inA/inB
- mul_valid_out  input  1  from multiplier
- mul_data  input  48  from multiplier product
- res_valid  output  NUM_REQ  one-hot result strobe, one cycle
- res_id  output  ID_W  index of result owner
- res_data  output  48  product, shared by all requesters
- in_flight  output  ID_W+2  operations issued but not yet returned
- err  output  1  sticky tag/valid mismatch flag

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i]. Requester holds req_a/req_b stable while req_valid is high and not granted. No backpressure on results: the requester must accept res_valid whenever it fires.
- Grant: req_ready is combinational from req_valid, hold and the priority pointer ptr. The first requesting index at or after ptr (mod NUM_REQ) wins, and at most one bit is set. With hold=1 or no requests, req_ready=0.
- Pointer: after a grant to index g, ptr <= (g+1) mod NUM_REQ. It is unchanged when there is no grant and resets to 0.
- Issue register: on a grant, it captures mul_a/mul_b from the winner and sets mul_valid_in=1 for exactly one cycle. Otherwise mul_valid_in=0 and mul_a/mul_b hold their last values.
- Tag pipeline: MUL_LAT-deep shift of {valid, id}. It enters with mul_valid_in and the issued id, and shifts every cycle unconditionally, so bubbles are preserved.
- Return: on mul_valid_out with tag-valid=1, register res_data=mul_data and res_id=tag id, and pulse res_valid[tag id] for one cycle.
- Mismatch: if mul_valid_out differs from tag-valid in any cycle, set err (sticky until rst). No res_valid is produced when mul_valid_out=0.
- in_flight: +1 on issue and -1 on return, with no net change when both happen in the same cycle. Maximum value is MUL_LAT+1.
- Throughput: one grant per cycle sustained; no dead cycles between back-to-back grants.
- Widths: products pass through unmodified (48 bits). The arbiter does no arithmetic on data.

## Timing
- Reset values: req_ready=0, mul_valid_in=0, mul_a=mul_b=0, res_valid=0, res_id=0, res_data=0, in_flight=0, err=0, ptr=0, all tag-valids=0.
- Grant at cycle T (handshake edge T) gives mul_valid_in high in cycle T+1 and mul_valid_out at T+1+MUL_LAT. res_valid is high in cycle T+2+MUL_LAT, a total of 6 cycles with defaults.
- Results return in issue order.
- Reset mid-operation clears all tags, so in-flight results are discarded. The multiplier shares the same reset (inverted at top) and must also flush. A mul_valid_out arriving after reset with no tag sets err.
- hold asserted in the same cycle as req_valid: no grant in that cycle. Deasserting hold grants on the same cycle it goes low.
- Simultaneous issue and return in one cycle are both handled, and in_flight stays unchanged.

## Test plan
- Single request: req_valid[2]=1, A=24'h800000, B=24'hC00000, others idle. Expect req_ready=4'b0100 at T, mul_valid_in at T+1, res_valid=4'b0100 with res_id=2 and res_data=48'h600000000000 at T+6, and in_flight 1->0.
- All four requesting continuously from reset: grants follow the sequence 0,1,2,3,0,1,… with one grant per cycle. Results return in the same order, six cycles after each grant, with operands A=i+1, B=3 giving products 3,6,9,12.
- Pointer fairness: after a grant to 3, requests from 1 and 3 at the same time. Expect a grant to 1 first, then 3.
- hold: hold=1 for 3 cycles with requests pending. Expect req_ready=0 while in-flight results still return. The first grant comes in the cycle hold falls.
- Reset with 4 operations in flight: assert rst for 1 cycle. Expect all outputs at reset values, no res_valid afterward, and err=0.
- Injected mismatch: force mul_valid_out=1 with an empty tag pipeline. Expect err=1 sticky, no res_valid, and err clears only on rst.
